pool_window_gen: RTL and testbench

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

---
 rtl/pool_window_gen.sv | 70 +++++++
 tb/tb_pool_window_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// 2x2 stride-2 window generator: raster 1-bit pixels in, 4-bit windows out, one cycle after the bottom-right pixel.
// Input stalls only while a produced window is held unconsumed (in_ready = !out_valid || out_ready).
module pool_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_pixel,
  input  logic       in_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_window,
  output logic       frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col, cur_col, col_prev;
  logic [RW-1:0]    row, cur_row;
  logic [IMG_W-1:0] line_buf;
  logic             bottom_left;
  logic             accept, load;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // sof overrides the counters so a misaligned stream resynchronises at the next frame start
  assign cur_col  = in_sof ? '0 : col;
  assign cur_row  = in_sof ? '0 : row;
  assign col_prev = cur_col - CW'(1);
  assign load     = accept && cur_row[0] && cur_col[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col         <= '0;
      row         <= '0;
      line_buf    <= '0;
      bottom_left <= 1'b0;
      out_valid   <= 1'b0;
      out_window  <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
        if (!cur_row[0])
          line_buf[cur_col] <= in_pixel;
        else if (!cur_col[0])
          bottom_left <= in_pixel;
      end
      if (load) begin
        out_window <= {in_pixel, bottom_left, line_buf[cur_col], line_buf[col_prev]};
        out_valid  <= 1'b1;
        frame_done <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      end
    end
  end
endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen (4x4): directed frames plus randomized traffic against a
// position-based reference model of the pooling windows.
module tb_pool_window_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_pixel = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, frame_done;
  logic [3:0] out_window;

  int n_cmp = 0;
  int n_bad = 0;

  pool_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // reference model: frame position plus the latest top-row pixel per column
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         rise_q[$];
  int         fd_q[$];
  bit         top_row[W];
  bit         bl_m, pend, exp_fd, prev_ov;
  int         pos, it, n_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) top_row[i] = 1'b0;
    bl_m = 1'b0; pos = 0; pend = 1'b0; exp_fd = 1'b0; prev_ov = 1'b0;
    exp_q.delete();
  endtask

  task automatic begin_test();
    it = 0; n_acc = 0;
    rise_q.delete(); fd_q.delete(); got_q.delete();
  endtask

  // one cycle, entered and left at a falling edge
  task automatic step(input bit iv, input bit pix, input bit sof, input bit ordy);
    int r, c;
    bit acc, ld, fd, consumed;
    logic [3:0] w;
    check("frame_done", frame_done, exp_fd);
    check("out_valid", out_valid, pend);
    if (out_valid && !prev_ov) rise_q.push_back(it);
    if (frame_done) fd_q.push_back(it);
    prev_ov = out_valid;
    in_valid = iv; in_pixel = pix; in_sof = sof; out_ready = ordy;
    #1;
    check("in_ready", in_ready, !pend || ordy);
    consumed = pend && ordy;
    if (consumed) begin
      if (exp_q.size() == 0) check("window_queue_len", exp_q.size(), 1);
      else begin
        w = exp_q.pop_front();
        check("out_window", out_window, w);
        got_q.push_back(out_window);
      end
    end
    acc = iv && (!pend || ordy);
    ld = 1'b0; fd = 1'b0;
    if (acc) begin
      n_acc++;
      if (sof) pos = 0;
      r = pos / W; c = pos % W;
      if (r % 2 == 0) top_row[c] = pix;
      else if (c % 2 == 0) bl_m = pix;
      else begin
        exp_q.push_back({pix, bl_m, top_row[c], top_row[c-1]});
        ld = 1'b1;
        fd = (r == H-1) && (c == W-1);
      end
      pos = (pos + 1) % (W*H);
    end
    pend = (pend && !consumed) || ld;
    exp_fd = fd;
    @(posedge clk);
    @(negedge clk);
    it++;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_window", out_window, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic check_windows(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({tag, "_count"}, got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check({tag, "_win"}, got_q[i], e[i]);
    check({tag, "_frame_done_count"}, fd_q.size(), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_in_ready", in_ready, 1);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;

    // window held under backpressure, then reset mid-stream
    begin_test();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i == 0, 1'b0);
    check("pre_rst_out_valid", out_valid, 1);
    do_reset();

    // all ones, no sof: next pixel after reset must land at (0,0)
    begin_test();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_windows("ones", 4'hF, 4'hF, 4'hF, 4'hF);
    check("ones_rise_count", rise_q.size(), 4);
    if (rise_q.size() == 4) begin
      check("ones_rise0", rise_q[0], 6);
      check("ones_rise1", rise_q[1], 8);
      check("ones_rise2", rise_q[2], 14);
      check("ones_rise3", rise_q[3], 16);
    end
    if (fd_q.size() == 1) check("ones_frame_done_at", fd_q[0], 16);

    begin_test();
    for (int i = 0; i < 16; i++) step(1'b1, i == 6, i == 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_windows("bl_single", 4'b0000, 4'b0100, 4'b0000, 4'b0000);

    begin_test();
    for (int i = 0; i < 16; i++) step(1'b1, i == 1, i == 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_windows("tr_single", 4'b0010, 4'b0000, 4'b0000, 4'b0000);

    // stall on the first window for three cycles
    begin_test();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i == 0, 1'b1);
    check("stall_out_valid", out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("stall_window", out_window, 4'hF);
      check("stall_in_ready", in_ready, 0);
    end
    for (int k = 0; k < 40 && got_q.size() < 4; k++) step(n_acc < 16, 1'b1, 1'b0, 1'b1);
    check_windows("stall", 4'hF, 4'hF, 4'hF, 4'hF);

    // sof on the 7th pixel resynchronises the counters
    begin_test();
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom % 2), i == 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    got_q.delete(); fd_q.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i == 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_windows("resync", 4'hF, 4'hF, 4'hF, 4'hF);

    // randomized traffic with occasional sof and one mid-run reset
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      step($urandom % 4 != 0, 1'($urandom % 2), $urandom % 64 == 0, $urandom % 3 != 0);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
